// File: rtl/firebird7_in_gate2_sol_pkg.sv
// Shared types and defaults for the sign-of-life monitor slice.
package firebird7_in_gate2_sol_pkg;

  localparam int DEFAULT_CNT_W       = 15;
  localparam int DEFAULT_SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2,
    SAT  = 2'd3
  } sol_state_e;

endpackage

// File: rtl/firebird7_in_gate2_sol_monitor_if.sv
// Control/status bundle between the sol monitor and its driver (the sol status TDR side).
// Level semantics, no handshake: sol_en/sol_rise_only are sampled every cycle, sol_clr acts
// in any cycle it is high, and all status signals (including the debug state) are flop outputs.
interface firebird7_in_gate2_sol_monitor_if
  import firebird7_in_gate2_sol_pkg::*;
#(
  parameter int CNT_W = DEFAULT_CNT_W
) ();

  logic             sol_in;
  logic             sol_en;
  logic             sol_clr;
  logic             sol_rise_only;
  logic             sol_out;
  logic [0:0]       sol_tog_status;
  logic [CNT_W-1:0] sol_cnt_status;
  sol_state_e       state;

  modport master (
    output sol_in, sol_en, sol_clr, sol_rise_only,
    input  sol_out, sol_tog_status, sol_cnt_status, state
  );

  modport slave (
    input  sol_in, sol_en, sol_clr, sol_rise_only,
    output sol_out, sol_tog_status, sol_cnt_status, state
  );

endinterface

// File: rtl/firebird7_in_gate2_sol_sync.sv
// Reset-to-0 multi-flop synchronizer; q is the last stage.
module firebird7_in_gate2_sol_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr <= '0;
    end else begin
      sr <= {sr[STAGES-2:0], d};
    end
  end

  assign q = sr[STAGES-1];

endmodule

// File: rtl/firebird7_in_gate2_sol_monitor.sv
// Sign-of-life monitor: synchronizes sol_in, detects edges and keeps a sticky toggle flag
// plus a saturating edge count, gated by a small IDLE/ARM/RUN/SAT state machine.
module firebird7_in_gate2_sol_monitor
  import firebird7_in_gate2_sol_pkg::*;
#(
  parameter int CNT_W       = DEFAULT_CNT_W,
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic                             ijtag_tck,
  input  logic                             ijtag_reset,
  firebird7_in_gate2_sol_monitor_if.slave  sol
);

  // A synchronizer shallower than two flops is never meaningful, so clamp it.
  localparam int STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
  localparam logic [CNT_W-1:0] CNT_PRE_MAX = {{(CNT_W-1){1'b1}}, 1'b0};

  logic             sync_q;
  logic             prev_q;
  logic             rise_only_q;
  logic             edge_det;
  logic             tog_q;
  logic [CNT_W-1:0] cnt_q;
  sol_state_e       state_q;

  firebird7_in_gate2_sol_sync #(
    .STAGES (STAGES)
  ) u_sync (
    .clk   (ijtag_tck),
    .rst_n (ijtag_reset),
    .d     (sol.sol_in),
    .q     (sync_q)
  );

  // Mode is registered so a change of sol_rise_only cannot itself create an edge mid-cycle.
  always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
    if (!ijtag_reset) begin
      prev_q      <= 1'b0;
      rise_only_q <= 1'b0;
    end else begin
      prev_q      <= sync_q;
      rise_only_q <= sol.sol_rise_only;
    end
  end

  assign edge_det = rise_only_q ? (sync_q & ~prev_q) : (sync_q ^ prev_q);

  always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
    if (!ijtag_reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tog_q   <= 1'b0;
    end else if (sol.sol_clr) begin
      cnt_q   <= '0;
      tog_q   <= 1'b0;
      state_q <= sol.sol_en ? ARM : IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (sol.sol_en) state_q <= ARM;
        end
        ARM: begin
          state_q <= sol.sol_en ? RUN : IDLE;
        end
        RUN: begin
          if (!sol.sol_en) begin
            state_q <= IDLE;
          end else if (edge_det) begin
            tog_q <= 1'b1;
            // Re-entering RUN with a full count goes straight back to SAT instead of wrapping.
            if (cnt_q == CNT_MAX) begin
              state_q <= SAT;
            end else begin
              cnt_q <= cnt_q + 1'b1;
              if (cnt_q == CNT_PRE_MAX) state_q <= SAT;
            end
          end
        end
        SAT: begin
          if (!sol.sol_en) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign sol.sol_out        = sync_q;
  assign sol.sol_tog_status = tog_q;
  assign sol.sol_cnt_status = cnt_q;
  assign sol.state          = state_q;

endmodule

// File: tb/tb_firebird7_in_gate2_sol_monitor.sv
// Directed bench for the sol monitor: a CNT_W=15 instance for the main checks and a
// CNT_W=4 instance on the same stimulus for saturation.
module tb_firebird7_in_gate2_sol_monitor;
  import firebird7_in_gate2_sol_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic sol_in;
  logic sol_en;
  logic sol_clr;
  logic sol_rise_only;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  firebird7_in_gate2_sol_monitor_if #(.CNT_W(15)) m15_if ();
  firebird7_in_gate2_sol_monitor_if #(.CNT_W(4))  m4_if ();

  assign m15_if.sol_in        = sol_in;
  assign m15_if.sol_en        = sol_en;
  assign m15_if.sol_clr       = sol_clr;
  assign m15_if.sol_rise_only = sol_rise_only;
  assign m4_if.sol_in         = sol_in;
  assign m4_if.sol_en         = sol_en;
  assign m4_if.sol_clr        = sol_clr;
  assign m4_if.sol_rise_only  = sol_rise_only;

  firebird7_in_gate2_sol_monitor #(.CNT_W(15), .SYNC_STAGES(2)) u_dut15 (
    .ijtag_tck   (clk),
    .ijtag_reset (rst_n),
    .sol         (m15_if.slave)
  );

  firebird7_in_gate2_sol_monitor #(.CNT_W(4), .SYNC_STAGES(2)) u_dut4 (
    .ijtag_tck   (clk),
    .ijtag_reset (rst_n),
    .sol         (m4_if.slave)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic toggle_n(input int n, input int gap);
    repeat (n) begin
      sol_in = ~sol_in;
      tick(gap);
    end
  endtask

  task automatic pulse_clr();
    sol_clr = 1'b1;
    tick(1);
    sol_clr = 1'b0;
  endtask

  initial begin
    rst_n         = 1'b0;
    sol_in        = 1'b0;
    sol_en        = 1'b0;
    sol_clr       = 1'b0;
    sol_rise_only = 1'b0;
    #12;
    check("rst_sol_out", 32'(m15_if.sol_out), 32'd0);
    check("rst_tog", 32'(m15_if.sol_tog_status), 32'd0);
    check("rst_cnt", 32'(m15_if.sol_cnt_status), 32'd0);
    check("rst_state", 32'(m15_if.state), 32'(IDLE));

    // Both-edge counting, 10 toggles 8 cycles apart
    tick(1);
    rst_n = 1'b1;
    tick(2);
    check("idle_no_en", 32'(m15_if.state), 32'(IDLE));
    sol_en = 1'b1;
    tick(1);
    check("arm_state", 32'(m15_if.state), 32'(ARM));
    tick(1);
    check("run_state", 32'(m15_if.state), 32'(RUN));
    sol_in = 1'b1;
    tick(1);
    check("sync_lag1", 32'(m15_if.sol_out), 32'd0);
    tick(1);
    check("sync_lag2", 32'(m15_if.sol_out), 32'd1);
    tick(6);
    toggle_n(9, 8);
    check("both_cnt", 32'(m15_if.sol_cnt_status), 32'd10);
    check("both_tog", 32'(m15_if.sol_tog_status), 32'd1);
    check("both_state", 32'(m15_if.state), 32'(RUN));

    // Rising edges only
    sol_rise_only = 1'b1;
    pulse_clr();
    check("clr_cnt", 32'(m15_if.sol_cnt_status), 32'd0);
    check("clr_tog", 32'(m15_if.sol_tog_status), 32'd0);
    tick(1);
    toggle_n(10, 8);
    check("rise_cnt", 32'(m15_if.sol_cnt_status), 32'd5);
    pulse_clr();
    tick(1);
    toggle_n(5, 8);
    check("rise3_cnt", 32'(m15_if.sol_cnt_status), 32'd3);
    sol_en = 1'b0;
    tick(1);
    check("dis_state", 32'(m15_if.state), 32'(IDLE));
    toggle_n(3, 8);
    check("dis_cnt_held", 32'(m15_if.sol_cnt_status), 32'd3);
    check("dis_tog_held", 32'(m15_if.sol_tog_status), 32'd1);
    check("dis_state2", 32'(m15_if.state), 32'(IDLE));

    // Saturation on the 4-bit instance
    sol_rise_only = 1'b0;
    sol_en = 1'b1;
    pulse_clr();
    tick(1);
    toggle_n(20, 4);
    check("sat_cnt4", 32'(m4_if.sol_cnt_status), 32'd15);
    check("sat_state4", 32'(m4_if.state), 32'(SAT));
    check("sat_tog4", 32'(m4_if.sol_tog_status), 32'd1);
    check("sat_cnt15", 32'(m15_if.sol_cnt_status), 32'd20);
    sol_en = 1'b0;
    tick(1);
    check("sat_idle4", 32'(m4_if.state), 32'(IDLE));
    check("sat_hold4", 32'(m4_if.sol_cnt_status), 32'd15);

    // Clear in the same cycle as a detected edge
    sol_en = 1'b1;
    pulse_clr();
    tick(1);
    toggle_n(7, 8);
    check("pre_clr_cnt", 32'(m15_if.sol_cnt_status), 32'd7);
    sol_in = ~sol_in;
    tick(2);
    sol_clr = 1'b1;
    tick(1);
    sol_clr = 1'b0;
    check("clr_edge_cnt", 32'(m15_if.sol_cnt_status), 32'd0);
    check("clr_edge_tog", 32'(m15_if.sol_tog_status), 32'd0);
    check("clr_edge_state", 32'(m15_if.state), 32'(ARM));
    tick(1);
    toggle_n(1, 8);
    check("post_clr_cnt", 32'(m15_if.sol_cnt_status), 32'd1);
    check("post_clr_tog", 32'(m15_if.sol_tog_status), 32'd1);

    // Enable while sol_out is already high
    sol_en = 1'b0;
    sol_in = 1'b1;
    tick(4);
    pulse_clr();
    check("hi_idle", 32'(m15_if.state), 32'(IDLE));
    check("hi_sol_out", 32'(m15_if.sol_out), 32'd1);
    sol_en = 1'b1;
    tick(1);
    check("hi_arm", 32'(m15_if.state), 32'(ARM));
    tick(7);
    check("hi_no_cnt", 32'(m15_if.sol_cnt_status), 32'd0);
    check("hi_no_tog", 32'(m15_if.sol_tog_status), 32'd0);
    toggle_n(1, 8);
    check("hi_first_cnt", 32'(m15_if.sol_cnt_status), 32'd1);

    // Asynchronous reset mid-RUN
    pulse_clr();
    tick(1);
    toggle_n(9, 8);
    check("pre_rst_cnt", 32'(m15_if.sol_cnt_status), 32'd9);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_cnt", 32'(m15_if.sol_cnt_status), 32'd0);
    check("arst_tog", 32'(m15_if.sol_tog_status), 32'd0);
    check("arst_sol_out", 32'(m15_if.sol_out), 32'd0);
    check("arst_state", 32'(m15_if.state), 32'(IDLE));
    #2;
    rst_n = 1'b1;
    check("rel_state", 32'(m15_if.state), 32'(IDLE));
    tick(1);
    check("rel_arm", 32'(m15_if.state), 32'(ARM));
    check("rel_sol_out0", 32'(m15_if.sol_out), 32'd0);
    tick(1);
    check("rel_run", 32'(m15_if.state), 32'(RUN));
    check("rel_sol_out1", 32'(m15_if.sol_out), 32'd1);
    check("rel_cnt0", 32'(m15_if.sol_cnt_status), 32'd0);
    tick(1);
    check("rel_cnt1", 32'(m15_if.sol_cnt_status), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
